// File: rtl/jm_pkg.sv
// Shared constants and width helpers for the job dispatch/completion arbiter.
package jm_pkg;

    localparam int ARB_MODE_RR    = 0;
    localparam int ARB_MODE_FIXED = 1;

    function automatic int jm_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Engine index width; a single engine still needs one bit.
    function automatic int kid_width(input int kn);
        return (jm_clog2(kn) < 1) ? 1 : jm_clog2(kn);
    endfunction

endpackage

// File: rtl/job_rr_arb.sv
// One-hot arbiter: round-robin (pointer = next search start) or fixed lowest-index priority.
module job_rr_arb
    import jm_pkg::*;
#(
    parameter int N    = 4,
    parameter int MODE = ARB_MODE_RR
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] i_req,
    input  logic         i_grant_en,
    output logic [N-1:0] o_grant
);

    localparam int PW = kid_width(N);

    logic [PW-1:0] r_ptr;
    logic          w_found;
    int            w_idx;
    int            w_win;

    always_comb begin
        o_grant = '0;
        w_found = 1'b0;
        w_idx   = 0;
        w_win   = 0;
        for (int i = 0; i < N; i++) begin
            w_idx = (MODE == ARB_MODE_FIXED) ? i : ((int'(r_ptr) + i) % N);
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                w_found        = 1'b1;
                w_win          = w_idx;
            end
        end
    end

    // Pointer moves only when the grant is actually taken.
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (MODE == ARB_MODE_RR && i_grant_en && w_found)
            r_ptr <= (w_win == N - 1) ? '0 : PW'(w_win + 1);
    end

endmodule

// File: rtl/job_dispatch_arb.sv
// Dispatches show-ahead job descriptors to KERNEL_NUM engines and funnels their
// completions through a second arbiter into a small FIFO toward job_completion.
module job_dispatch_arb
    import jm_pkg::*;
#(
    parameter int HOST_DWIDTH  = 1024,
    parameter int RETURN_WIDTH = 41,
    parameter int KERNEL_NUM   = 4,
    parameter int CMPL_DEPTH   = 8,
    parameter int ARB_MODE     = ARB_MODE_RR,
    localparam int KID_W       = kid_width(KERNEL_NUM)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [KERNEL_NUM-1:0]              kernel_en_i,
    input  logic                               flush_i,
    input  logic                               dsc_ready_i,
    input  logic [HOST_DWIDTH-1:0]             dsc_data_i,
    output logic                               dsc_pull_o,
    output logic [KERNEL_NUM-1:0]              engine_start,
    output logic [HOST_DWIDTH-1:0]             engine_data,
    input  logic [KERNEL_NUM-1:0]              engine_ready,
    input  logic [KERNEL_NUM-1:0]              complete_ready,
    input  logic [RETURN_WIDTH*KERNEL_NUM-1:0] complete_data,
    output logic [KERNEL_NUM-1:0]              complete_accept,
    input  logic                               complete_ready_i,
    output logic                               complete_push_o,
    output logic [RETURN_WIDTH-1:0]            return_data_o,
    output logic [KID_W-1:0]                   return_kid_o,
    output logic [KERNEL_NUM-1:0]              busy_o,
    output logic                               idle_o,
    output logic [31:0]                        dispatch_cnt_o,
    output logic [31:0]                        cmpl_cnt_o
);

    localparam int AW = jm_clog2(CMPL_DEPTH);
    localparam int CW = AW + 1;

    logic [KERNEL_NUM-1:0]   r_busy, r_start;
    logic [KERNEL_NUM-1:0]   w_elig, w_dgrant, w_cand, w_cgrant, w_accept;
    logic                    w_disp, w_acc, w_pop, w_full, w_empty;
    logic [HOST_DWIDTH-1:0]  r_edata;
    logic [RETURN_WIDTH-1:0] r_mdata [CMPL_DEPTH];
    logic [KID_W-1:0]        r_mkid  [CMPL_DEPTH];
    logic [AW-1:0]           r_wptr, r_rptr;
    logic [CW-1:0]           r_cnt;
    logic [KID_W-1:0]        w_ckid;
    logic [RETURN_WIDTH-1:0] w_cdata;
    logic [31:0]             r_dcnt, r_ccnt;

    // Registered busy both gates dispatch and qualifies completions, so one
    // engine can never be started and accepted in the same cycle.
    assign w_elig   = engine_ready & kernel_en_i & ~r_busy;
    assign w_disp   = ~rst & ~flush_i & dsc_ready_i & (|w_elig);
    assign w_full   = (r_cnt == CW'(CMPL_DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign w_cand   = complete_ready & r_busy;
    assign w_acc    = ~rst & (|w_cand) & ~w_full;
    assign w_pop    = ~rst & complete_ready_i & ~w_empty;
    assign w_accept = w_acc ? w_cgrant : '0;

    job_rr_arb #(.N(KERNEL_NUM), .MODE(ARB_MODE)) u_disp_arb (
        .clk(clk), .rst(rst), .i_req(w_elig), .i_grant_en(w_disp), .o_grant(w_dgrant)
    );

    job_rr_arb #(.N(KERNEL_NUM), .MODE(ARB_MODE)) u_cmpl_arb (
        .clk(clk), .rst(rst), .i_req(w_cand), .i_grant_en(w_acc), .o_grant(w_cgrant)
    );

    always_comb begin
        w_ckid  = '0;
        w_cdata = '0;
        for (int k = 0; k < KERNEL_NUM; k++) begin
            if (w_cgrant[k]) begin
                w_ckid  = KID_W'(k);
                w_cdata = complete_data[k*RETURN_WIDTH +: RETURN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy  <= '0;
            r_start <= '0;
            r_edata <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_cnt   <= '0;
            r_dcnt  <= '0;
            r_ccnt  <= '0;
            for (int i = 0; i < CMPL_DEPTH; i++) begin
                r_mdata[i] <= '0;
                r_mkid[i]  <= '0;
            end
        end else begin
            r_start <= w_disp ? w_dgrant : '0;
            r_busy  <= (r_busy | (w_disp ? w_dgrant : '0)) & ~w_accept;
            if (w_disp) begin
                r_edata <= dsc_data_i;
                r_dcnt  <= r_dcnt + 32'd1;
            end
            if (w_acc) begin
                r_mdata[r_wptr] <= w_cdata;
                r_mkid[r_wptr]  <= w_ckid;
                r_wptr          <= r_wptr + 1'b1;
                r_ccnt          <= r_ccnt + 32'd1;
            end
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_cnt <= r_cnt + CW'(w_acc) - CW'(w_pop);
        end
    end

    assign dsc_pull_o      = w_disp;
    assign engine_start    = r_start;
    assign engine_data     = r_edata;
    assign complete_accept = w_accept;
    assign complete_push_o = w_pop;
    assign return_data_o   = r_mdata[r_rptr];
    assign return_kid_o    = r_mkid[r_rptr];
    assign busy_o          = r_busy;
    assign idle_o          = ~(|r_busy) & w_empty;
    assign dispatch_cnt_o  = r_dcnt;
    assign cmpl_cnt_o      = r_ccnt;

endmodule

// File: tb/tb_job_dispatch_arb.sv
// Directed bench: u_a is round-robin with a 2-deep FIFO, u_b is fixed priority
// with a 4-deep FIFO; both see the same stimulus, each test checks one of them.
module tb_job_dispatch_arb;

    localparam int HW = 64;
    localparam int RW = 41;
    localparam int KN = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [KN-1:0]  kernel_en_i, engine_ready, complete_ready;
    logic           flush_i, dsc_ready_i, complete_ready_i;
    logic [HW-1:0]  dsc_data_i;
    logic [RW*KN-1:0] complete_data;

    logic          a_pull, a_push, a_idle, b_pull, b_push, b_idle;
    logic [KN-1:0] a_start, a_acc, a_busy, b_start, b_acc, b_busy;
    logic [HW-1:0] a_edata, b_edata;
    logic [RW-1:0] a_rdata, b_rdata;
    logic [1:0]    a_kid, b_kid;
    logic [31:0]   a_dcnt, a_ccnt, b_dcnt, b_ccnt;

    int n_vec = 0;
    int n_err = 0;

    logic [HW-1:0] d_tab [4];
    logic [RW-1:0] p_tab [4];
    logic [3:0]    pulls_exp;

    always #5 clk = ~clk;

    job_dispatch_arb #(.HOST_DWIDTH(HW), .RETURN_WIDTH(RW), .KERNEL_NUM(KN),
                       .CMPL_DEPTH(2), .ARB_MODE(0)) u_a (
        .clk(clk), .rst(rst), .kernel_en_i(kernel_en_i), .flush_i(flush_i),
        .dsc_ready_i(dsc_ready_i), .dsc_data_i(dsc_data_i), .dsc_pull_o(a_pull),
        .engine_start(a_start), .engine_data(a_edata), .engine_ready(engine_ready),
        .complete_ready(complete_ready), .complete_data(complete_data),
        .complete_accept(a_acc), .complete_ready_i(complete_ready_i),
        .complete_push_o(a_push), .return_data_o(a_rdata), .return_kid_o(a_kid),
        .busy_o(a_busy), .idle_o(a_idle), .dispatch_cnt_o(a_dcnt), .cmpl_cnt_o(a_ccnt)
    );

    job_dispatch_arb #(.HOST_DWIDTH(HW), .RETURN_WIDTH(RW), .KERNEL_NUM(KN),
                       .CMPL_DEPTH(4), .ARB_MODE(1)) u_b (
        .clk(clk), .rst(rst), .kernel_en_i(kernel_en_i), .flush_i(flush_i),
        .dsc_ready_i(dsc_ready_i), .dsc_data_i(dsc_data_i), .dsc_pull_o(b_pull),
        .engine_start(b_start), .engine_data(b_edata), .engine_ready(engine_ready),
        .complete_ready(complete_ready), .complete_data(complete_data),
        .complete_accept(b_acc), .complete_ready_i(complete_ready_i),
        .complete_push_o(b_push), .return_data_o(b_rdata), .return_kid_o(b_kid),
        .busy_o(b_busy), .idle_o(b_idle), .dispatch_cnt_o(b_dcnt), .cmpl_cnt_o(b_ccnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        kernel_en_i      = '0;
        engine_ready     = '0;
        complete_ready   = '0;
        flush_i          = 1'b0;
        dsc_ready_i      = 1'b0;
        dsc_data_i       = '0;
        complete_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Feeds four descriptors to four ready, enabled engines, one per cycle.
    task automatic dispatch_all4();
        kernel_en_i  = 4'hF;
        engine_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            dsc_ready_i = 1'b1;
            dsc_data_i  = d_tab[i];
            tick();
        end
        dsc_ready_i = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            d_tab[i] = 64'hD0D0_1234_0000_0000 + 64'(i);
            p_tab[i] = 41'h155_0000_00A0 + 41'(i * 3);
        end
        complete_data = {p_tab[3], p_tab[2], p_tab[1], p_tab[0]};

        // Reset state
        do_reset();
        #1;
        chk("rst_start", 64'(a_start), 64'h0);
        chk("rst_busy", 64'(a_busy), 64'h0);
        chk("rst_idle", 64'(a_idle), 64'h1);
        chk("rst_dcnt", 64'(a_dcnt), 64'h0);
        chk("rst_pull", 64'(a_pull), 64'h0);
        chk("rst_rdata", 64'(a_rdata), 64'h0);

        // Test 1: RR back-to-back dispatch to engines 0..3
        kernel_en_i  = 4'hF;
        engine_ready = 4'hF;
        for (int i = 0; i < 4; i++) begin
            dsc_ready_i = 1'b1;
            dsc_data_i  = d_tab[i];
            #1;
            chk("t1_pull", 64'(a_pull), 64'h1);
            tick();
            chk("t1_start", 64'(a_start), 64'(4'b0001 << i));
            chk("t1_data", a_edata, d_tab[i]);
        end
        dsc_ready_i = 1'b0;
        #1;
        chk("t1_nopull", 64'(a_pull), 64'h0);
        tick();
        chk("t1_start_off", 64'(a_start), 64'h0);
        chk("t1_data_hold", a_edata, d_tab[3]);
        chk("t1_dcnt", 64'(a_dcnt), 64'd4);
        chk("t1_busy", 64'(a_busy), 64'hF);

        // Test 2: mask 0101, only engines 0 and 2 get work
        do_reset();
        kernel_en_i  = 4'b0101;
        engine_ready = 4'hF;
        dsc_ready_i  = 1'b1;
        pulls_exp    = 4'b0011;
        begin
            int di;
            di = 0;
            for (int c = 0; c < 4; c++) begin
                dsc_data_i = d_tab[di];
                #1;
                chk("t2_pull", 64'(a_pull), 64'(pulls_exp[c]));
                if (a_pull) di++;
                tick();
            end
        end
        chk("t2_busy", 64'(a_busy), 64'b0101);
        chk("t2_dcnt", 64'(a_dcnt), 64'd2);
        chk("t2_edata", a_edata, d_tab[1]);
        dsc_ready_i = 1'b0;

        // Test 5: completion from a non-busy engine is ignored
        complete_ready = 4'b0010;
        #1;
        chk("t5_acc", 64'(a_acc), 64'h0);
        tick();
        chk("t5_ccnt", 64'(a_ccnt), 64'h0);
        chk("t5_busy", 64'(a_busy), 64'b0101);
        complete_ready = '0;

        // Test 3: simultaneous completions into a 2-deep FIFO
        do_reset();
        dispatch_all4();
        complete_ready   = 4'hF;
        complete_ready_i = 1'b0;
        #1;
        chk("t3_acc0", 64'(a_acc), 64'b0001);
        tick();
        chk("t3_acc1", 64'(a_acc), 64'b0010);
        tick();
        chk("t3_full_acc", 64'(a_acc), 64'h0);
        chk("t3_ccnt2", 64'(a_ccnt), 64'd2);
        chk("t3_busy", 64'(a_busy), 64'b1100);
        tick();
        chk("t3_full_acc2", 64'(a_acc), 64'h0);
        chk("t3_head_kid", 64'(a_kid), 64'd0);
        complete_ready_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_push", 64'(a_push), 64'h1);
            chk("t3_kid", 64'(a_kid), 64'(k));
            chk("t3_rdata", 64'(a_rdata), 64'(p_tab[k]));
            tick();
        end
        chk("t3_push_off", 64'(a_push), 64'h0);
        chk("t3_ccnt4", 64'(a_ccnt), 64'd4);
        chk("t3_idle", 64'(a_idle), 64'h1);
        complete_ready   = '0;
        complete_ready_i = 1'b0;

        // Test 4: fixed priority, engines 1 and 3 ready
        do_reset();
        kernel_en_i  = 4'hF;
        engine_ready = 4'b1010;
        dsc_ready_i  = 1'b1;
        dsc_data_i   = d_tab[0];
        #1;
        chk("t4_pull0", 64'(b_pull), 64'h1);
        tick();
        chk("t4_start0", 64'(b_start), 64'b0010);
        dsc_data_i = d_tab[1];
        tick();
        chk("t4_start1", 64'(b_start), 64'b1000);
        chk("t4_pull_none", 64'(b_pull), 64'h0);
        chk("t4_busy", 64'(b_busy), 64'b1010);
        dsc_ready_i = 1'b0;

        // Test 6: reset mid-burst with 3 FIFO entries
        do_reset();
        dispatch_all4();
        complete_ready = 4'hF;
        tick();
        tick();
        tick();
        chk("t6_ccnt3", 64'(b_ccnt), 64'd3);
        chk("t6_idle_pre", 64'(b_idle), 64'h0);
        rst = 1'b1;
        #1;
        chk("t6_acc_in_rst", 64'(b_acc), 64'h0);
        tick();
        rst              = 1'b0;
        complete_ready   = '0;
        complete_ready_i = 1'b1;
        #1;
        chk("t6_idle", 64'(b_idle), 64'h1);
        chk("t6_busy", 64'(b_busy), 64'h0);
        chk("t6_ccnt", 64'(b_ccnt), 64'h0);
        chk("t6_dcnt", 64'(b_dcnt), 64'h0);
        chk("t6_push", 64'(b_push), 64'h0);
        chk("t6_start", 64'(b_start), 64'h0);
        chk("t6_pull", 64'(b_pull), 64'h0);
        tick();
        chk("t6_push2", 64'(b_push), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
